// File: rtl/calc_mailbox_responder_if.sv
//----------------------------------------------------------------------
// calc_mailbox_responder_if -- front-end <-> responder bus | rev 1.0
//----------------------------------------------------------------------
`default_nettype none

interface calc_mailbox_responder_if;
  logic        mem_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        cpu_en;
  logic [31:0] result;
  logic [31:0] status;
  logic        busy;
  logic        err;

  modport master (
    output mem_en, addr, wdata, cpu_en,
    input  result, status, busy, err
  );

  modport slave (
    input  mem_en, addr, wdata, cpu_en,
    output result, status, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/calc_mailbox_responder.sv
//----------------------------------------------------------------------
// calc_mailbox_responder -- mailbox-fed add/sub/mul/div responder | rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module calc_mailbox_responder #(
  parameter int          OPW          = 16,
  parameter logic [31:0] MAILBOX_ADDR = 32'd1,
  parameter logic [31:0] CLEAR_ADDR   = 32'd100
) (
  input  wire logic               clk,
  input  wire logic               nrst,
  calc_mailbox_responder_if.slave bus
);

  localparam int CW = $clog2(OPW + 1);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_CALC = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  localparam logic [3:0] C_OP_ADD = 4'b1000;
  localparam logic [3:0] C_OP_SUB = 4'b0100;
  localparam logic [3:0] C_OP_MUL = 4'b0010;
  localparam logic [3:0] C_OP_DIV = 4'b0001;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_mem_en_q;
  logic             r_cpu_en_q;
  logic             w_wr_ev;
  logic             w_start_ev;
  logic             w_wr_mbox;
  logic             w_wr_clr;
  logic [1:0]       r_ptr;
  logic [OPW-1:0]   r_op1;
  logic [OPW-1:0]   r_op2;
  logic [3:0]       r_opc;
  logic [CW-1:0]    r_cnt;
  logic             w_last;
  logic [2*OPW-1:0] r_mcand;
  logic [2*OPW-1:0] r_prod;
  logic [2*OPW-1:0] w_prod_nxt;
  logic [OPW-1:0]   r_mplier;
  logic [OPW-1:0]   r_rem;
  logic [OPW-1:0]   r_quot;
  logic [OPW:0]     w_rem_sh;
  logic [OPW:0]     w_rem_diff;
  logic             w_q_bit;
  logic [OPW:0]     w_sum;
  logic [OPW-1:0]   w_diff;
  logic             w_quick;
  logic             w_quick_err;
  logic [31:0]      w_quick_res;
  logic [31:0]      r_result;
  logic             r_err;
  logic             w_unused_wdata;

  assign w_wr_ev        = bus.mem_en & ~r_mem_en_q;
  assign w_start_ev     = bus.cpu_en & ~r_cpu_en_q;
  assign w_wr_mbox      = w_wr_ev && (bus.addr == MAILBOX_ADDR);
  assign w_wr_clr       = w_wr_ev && (bus.addr == CLEAR_ADDR);
  assign w_unused_wdata = ^bus.wdata[31:OPW];

  assign w_last     = (r_cnt == CW'(OPW - 1));
  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_rem_sh   = {r_rem, r_quot[OPW-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_op2};
  assign w_q_bit    = ~w_rem_diff[OPW];
  assign w_sum      = {1'b0, r_op1} + {1'b0, r_op2};
  assign w_diff     = r_op1 - r_op2;

  // Single-cycle outcomes; mul and div by a non-zero divisor iterate instead.
  always_comb begin
    w_quick     = 1'b1;
    w_quick_err = 1'b0;
    w_quick_res = '0;
    case (r_opc)
      C_OP_ADD: w_quick_res = 32'(w_sum);
      C_OP_SUB: begin
        if (r_op1 >= r_op2) w_quick_res = 32'(w_diff);
        else                w_quick_err = 1'b1;
      end
      C_OP_MUL: w_quick = 1'b0;
      C_OP_DIV: begin
        if (r_op2 == '0) w_quick_err = 1'b1;
        else             w_quick     = 1'b0;
      end
      default:  w_quick_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= C_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE:  if (w_start_ev && (r_ptr == 2'd3)) w_state_nxt = C_CALC;
      C_CALC:  if (w_quick || w_last) w_state_nxt = C_DONE;
      C_DONE:  if (w_wr_clr || w_wr_mbox) w_state_nxt = C_IDLE;
      default: w_state_nxt = C_IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (r_state == C_CALC);
    bus.status = (r_state == C_DONE) ? 32'hFFFF_FFFF : 32'h0;
    bus.result = r_result;
    bus.err    = r_err;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mem_en_q <= 1'b0;
      r_cpu_en_q <= 1'b0;
      r_ptr      <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_opc      <= '0;
      r_cnt      <= '0;
      r_mcand    <= '0;
      r_prod     <= '0;
      r_mplier   <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_result   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_mem_en_q <= bus.mem_en;
      r_cpu_en_q <= bus.cpu_en;
      case (r_state)
        C_IDLE: begin
          if (w_wr_mbox && (r_ptr != 2'd3)) begin
            case (r_ptr)
              2'd0:    r_op1 <= bus.wdata[OPW-1:0];
              2'd1:    r_opc <= bus.wdata[3:0];
              default: r_op2 <= bus.wdata[OPW-1:0];
            endcase
            r_ptr <= r_ptr + 2'd1;
          end else if (w_wr_clr) begin
            r_ptr <= '0;
            r_op1 <= '0;
            r_opc <= '0;
            r_op2 <= '0;
            r_err <= 1'b0;
          end
          // The start sees the pointer value from before any same-cycle write.
          if (w_start_ev) begin
            if (r_ptr == 2'd3) begin
              r_cnt    <= '0;
              r_prod   <= '0;
              r_mcand  <= {{OPW{1'b0}}, r_op1};
              r_mplier <= r_op2;
              r_rem    <= '0;
              r_quot   <= r_op1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        C_CALC: begin
          if (w_quick) begin
            r_result <= w_quick_res;
            r_err    <= r_err | w_quick_err;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (r_opc == C_OP_MUL) begin
              r_prod   <= w_prod_nxt;
              r_mcand  <= r_mcand << 1;
              r_mplier <= r_mplier >> 1;
              if (w_last) r_result <= 32'(w_prod_nxt);
            end else begin
              r_rem  <= w_q_bit ? w_rem_diff[OPW-1:0] : w_rem_sh[OPW-1:0];
              r_quot <= {r_quot[OPW-2:0], w_q_bit};
              if (w_last) r_result <= 32'({r_quot[OPW-2:0], w_q_bit});
            end
          end
        end
        C_DONE: begin
          if (w_wr_clr) begin
            r_ptr    <= '0;
            r_op1    <= '0;
            r_opc    <= '0;
            r_op2    <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
          end else if (w_wr_mbox) begin
            r_op1    <= bus.wdata[OPW-1:0];
            r_ptr    <= 2'd1;
            r_err    <= 1'b0;
            r_result <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_calc_mailbox_responder.sv
//----------------------------------------------------------------------
// tb_calc_mailbox_responder -- scoreboard bench for the mailbox responder | rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module tb_calc_mailbox_responder;

  localparam int          OPW  = 16;
  localparam logic [31:0] MBOX = 32'd1;
  localparam logic [31:0] CLR  = 32'd100;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  always #5 clk = ~clk;

  calc_mailbox_responder_if bus ();

  calc_mailbox_responder #(
    .OPW         (OPW),
    .MAILBOX_ADDR(MBOX),
    .CLEAR_ADDR  (CLR)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: plain arithmetic on the truncated operands.
  function automatic exp_t ref_model(input logic [31:0] a32, input logic [31:0] opc32,
                                     input logic [31:0] b32, input logic sticky);
    exp_t        e;
    int unsigned a;
    int unsigned b;
    a     = a32 % (32'd1 << OPW);
    b     = b32 % (32'd1 << OPW);
    e.res = 32'd0;
    e.err = sticky;
    e.cyc = 1;
    case (opc32 & 32'hF)
      32'h8: e.res = a + b;
      32'h4: if (a >= b) e.res = a - b; else e.err = 1'b1;
      32'h2: begin e.res = a * b; e.cyc = OPW; end
      32'h1: if (b == 0) e.err = 1'b1; else begin e.res = a / b; e.cyc = OPW; end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Monitor: pops one expectation each time status rises.
  logic [31:0] prev_status = '0;
  int          busy_cnt    = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!nrst) begin
      busy_cnt    = 0;
      prev_status = '0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.status != 32'h0 && prev_status == 32'h0) begin
        if (sb.size() == 0) begin
          check("unexpected_done_status", bus.status, 32'h0);
        end else begin
          e = sb.pop_front();
          check("result", bus.result, e.res);
          check("err", {31'h0, bus.err}, {31'h0, e.err});
          check("busy_cycles", busy_cnt, e.cyc);
          check("status_word", bus.status, 32'hFFFF_FFFF);
          check("busy_at_done", {31'h0, bus.busy}, 32'h0);
        end
        busy_cnt = 0;
      end
      prev_status = bus.status;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    tick;
    bus.addr   = a;
    bus.wdata  = d;
    bus.mem_en = 1'b1;
    tick;
    bus.mem_en = 1'b0;
  endtask

  task automatic start;
    tick;
    bus.cpu_en = 1'b1;
    tick;
    bus.cpu_en = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic clear_chk;
    wr(CLR, $urandom);
    @(negedge clk);
    check("clr_status", bus.status, 32'h0);
    check("clr_err", {31'h0, bus.err}, 32'h0);
    check("clr_result", bus.result, 32'h0);
  endtask

  task automatic txn(input logic [31:0] a, input logic [31:0] opc, input logic [31:0] b,
                     input bit disturb);
    exp_t e;
    wr(MBOX, a);
    if ($urandom_range(0, 3) == 0) wr(32'd2 + ($urandom % 90), $urandom);
    wr(MBOX, opc);
    wr(MBOX, b);
    e = ref_model(a, opc, b, 1'b0);
    sb.push_back(e);
    start;
    if (disturb && e.cyc > 2) begin
      tick;
      wr(MBOX, 32'hDEAD);
      start;
    end
    drain;
    repeat (3) @(negedge clk);
    check("hold_result", bus.result, e.res);
    check("hold_status", bus.status, 32'hFFFF_FFFF);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] ropc;
    logic [3:0]  bad_ops [5];
    exp_t        e;

    bad_ops = '{4'h0, 4'h3, 4'h5, 4'hF, 4'hC};
    bus.mem_en = 1'b0;
    bus.cpu_en = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;

    repeat (3) @(negedge clk);
    check("rst_result", bus.result, 32'h0);
    check("rst_status", bus.status, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_err", {31'h0, bus.err}, 32'h0);
    nrst = 1'b1;

    // Directed cases
    txn(32'd12, 32'h8, 32'd34, 1'b0);
    txn(32'd99, 32'h2, 32'd99, 1'b1);
    txn(32'd97, 32'h1, 32'd7, 1'b1);
    txn(32'd97, 32'h1, 32'd0, 1'b0);
    txn(32'd5, 32'h4, 32'd9, 1'b0);
    clear_chk;

    // Start with only one slot filled, then a held write counting once
    wr(MBOX, 32'd5);
    start;
    @(negedge clk);
    check("short_start_err", {31'h0, bus.err}, 32'h1);
    check("short_start_status", bus.status, 32'h0);
    check("short_start_busy", {31'h0, bus.busy}, 32'h0);
    tick;
    bus.addr   = MBOX;
    bus.wdata  = 32'h8;
    bus.mem_en = 1'b1;
    repeat (10) tick;
    bus.mem_en = 1'b0;
    wr(MBOX, 32'd9);
    sb.push_back(ref_model(32'd5, 32'h8, 32'd9, 1'b1));
    start;
    drain;
    clear_chk;

    // Write and start in the same cycle with two slots filled
    wr(MBOX, 32'd20);
    wr(MBOX, 32'h4);
    tick;
    bus.addr   = MBOX;
    bus.wdata  = 32'd6;
    bus.mem_en = 1'b1;
    bus.cpu_en = 1'b1;
    tick;
    bus.mem_en = 1'b0;
    bus.cpu_en = 1'b0;
    @(negedge clk);
    check("race_err", {31'h0, bus.err}, 32'h1);
    check("race_busy", {31'h0, bus.busy}, 32'h0);
    check("race_status", bus.status, 32'h0);
    sb.push_back(ref_model(32'd20, 32'h4, 32'd6, 1'b1));
    start;
    drain;

    // Randomized transactions
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1) clear_chk;
      ra   = $urandom;
      rb   = $urandom;
      ropc = $urandom & 32'hFFFF_FFF0;
      case ($urandom_range(0, 4))
        0: ropc = ropc | 32'h8;
        1: ropc = ropc | 32'h4;
        2: ropc = ropc | 32'h2;
        3: ropc = ropc | 32'h1;
        default: ropc = ropc | {28'h0, bad_ops[$urandom_range(0, 4)]};
      endcase
      case ($urandom_range(0, 3))
        0: rb = rb & 32'hFF;
        1: rb = rb & 32'hFFFF_0000;
        2: ra = ra & 32'hFF;
        default: ;
      endcase
      txn(ra, ropc, rb, $urandom_range(0, 1) == 1);
    end

    // Asynchronous reset in the middle of a multiply
    clear_chk;
    wr(MBOX, 32'd99);
    wr(MBOX, 32'h2);
    wr(MBOX, 32'd99);
    e = ref_model(32'd99, 32'h2, 32'd99, 1'b0);
    sb.push_back(e);
    start;
    repeat (4) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("abort_busy", {31'h0, bus.busy}, 32'h0);
    check("abort_status", bus.status, 32'h0);
    check("abort_result", bus.result, 32'h0);
    check("abort_err", {31'h0, bus.err}, 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    tick;
    nrst = 1'b1;
    repeat (40) @(negedge clk);
    check("post_abort_status", bus.status, 32'h0);
    check("post_abort_busy", {31'h0, bus.busy}, 32'h0);
    txn(32'd1000, 32'h1, 32'd33, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
